score_lives_keeper: RTL and testbench

//  Downstream of game_controller: consumes its scoreUpdate pulses and alien-shot/player hits.

---
 rtl/score_lives_keeper_pkg.sv | 37 +++
 rtl/score_lives_keeper_if.sv | 26 ++
 rtl/score_lives_keeper_bcd_counter4.sv | 26 ++
 rtl/score_lives_keeper.sv | 141 ++++++++++++++
 tb/tb_score_lives_keeper.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/score_lives_keeper_pkg.sv
// rtl/score_lives_keeper_pkg.sv - shared types, constants and BCD helper for the score/lives keeper
package score_lives_keeper_pkg;

    typedef logic [15:0] bcd4_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PLAY   = 2'd1,
        INVULN = 2'd2,
        OVER   = 2'd3
    } state_e;

    localparam logic [7:0] ALIEN_PTS = 8'd10;
    localparam logic [7:0] BONUS_PTS = 8'd100;
    localparam logic [8:0] PEND_MAX  = 9'd511;
    localparam bcd4_t      BCD_MAX   = 16'h9999;

    // Ripple +1 through four BCD digits; callers handle the 9999 ceiling.
    function automatic bcd4_t bcd4_inc(input bcd4_t v);
        bcd4_t r;
        logic  carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (v[i*4 +: 4] == 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/score_lives_keeper_if.sv
// rtl/score_lives_keeper_if.sv - game_controller <-> score/lives keeper signal bundle
interface score_lives_keeper_if;
    import score_lives_keeper_pkg::*;

    logic        startOfFrame;
    logic        startGame;
    logic [7:0]  scoreUpdate;
    logic        playerHit;
    bcd4_t       scoreBCD;
    bcd4_t       highScoreBCD;
    logic [2:0]  lives;
    logic        gameLose;
    logic        invulnerable;
    logic        busy;

    modport master (
        output startOfFrame, startGame, scoreUpdate, playerHit,
        input  scoreBCD, highScoreBCD, lives, gameLose, invulnerable, busy
    );

    modport slave (
        input  startOfFrame, startGame, scoreUpdate, playerHit,
        output scoreBCD, highScoreBCD, lives, gameLose, invulnerable, busy
    );

endinterface

// File: rtl/score_lives_keeper_bcd_counter4.sv
// rtl/score_lives_keeper_bcd_counter4.sv - 4-digit BCD incrementer with clear, saturating at 9999
module bcd_counter4
    import score_lives_keeper_pkg::*;
(
    input  logic  clk,
    input  logic  resetN,
    input  logic  i_clr,
    input  logic  i_en,
    output bcd4_t o_count
);

    bcd4_t r_count;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en && (r_count != BCD_MAX)) begin
            r_count <= bcd4_inc(r_count);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/score_lives_keeper.sv
// rtl/score_lives_keeper.sv - score, high score and lives keeper fed by game_controller
module score_lives_keeper
    import score_lives_keeper_pkg::*;
#(
    parameter int    START_LIVES    = 3,
    parameter int    MAX_LIVES      = 5,
    parameter int    INVULN_FRAMES  = 60,
    parameter bcd4_t EXTRA_LIFE_BCD = 16'h1500
) (
    input logic                 clk,
    input logic                 resetN,
    score_lives_keeper_if.slave bus
);

    localparam int FCW = $clog2(INVULN_FRAMES + 1);

    state_e          r_state;
    state_e          w_state_next;
    logic            r_start_d;
    logic            r_hit_sem;
    logic            r_extra_flag;
    logic [8:0]      r_pend;
    logic [FCW-1:0]  r_frame_cnt;
    logic [2:0]      r_lives;
    bcd4_t           r_high;

    bcd4_t           w_score;
    logic            w_start;
    logic            w_in_game;
    logic            w_hit_acc;
    logic            w_bonus;
    logic            w_drain;
    logic [7:0]      w_upd;
    logic [9:0]      w_pend_sum;
    logic [8:0]      w_pend_next;

    assign w_start   = bus.startGame & ~r_start_d;
    assign w_in_game = (r_state == PLAY) || (r_state == INVULN);
    assign w_hit_acc = (r_state == PLAY) && bus.playerHit && !r_hit_sem && !w_start;
    // A bonus colliding with an accepted hit waits a cycle; if the hit ended the game it never lands.
    assign w_bonus   = w_in_game && !w_start && !w_hit_acc && !r_extra_flag
                       && (w_score >= EXTRA_LIFE_BCD);
    assign w_drain   = (r_pend != 9'd0);
    assign w_upd     = (w_in_game && !w_start) ? bus.scoreUpdate : 8'd0;

    always_comb begin
        w_pend_sum  = {1'b0, r_pend} + {2'b00, w_upd} - {9'd0, w_drain};
        w_pend_next = (w_pend_sum > {1'b0, PEND_MAX}) ? PEND_MAX : w_pend_sum[8:0];
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_start) begin
            w_state_next = PLAY;
        end else begin
            case (r_state)
                PLAY: begin
                    if (w_hit_acc) begin
                        w_state_next = (r_lives == 3'd1) ? OVER : INVULN;
                    end
                end
                INVULN: begin
                    if (r_frame_cnt == FCW'(INVULN_FRAMES)) begin
                        w_state_next = PLAY;
                    end
                end
                default: w_state_next = r_state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_start_d    <= 1'b0;
            r_hit_sem    <= 1'b0;
            r_extra_flag <= 1'b0;
            r_pend       <= 9'd0;
            r_frame_cnt  <= '0;
            r_lives      <= 3'(START_LIVES);
            r_high       <= '0;
        end else begin
            r_start_d <= bus.startGame;
            r_high    <= (w_score > r_high) ? w_score : r_high;
            if (w_start) begin
                r_hit_sem    <= 1'b0;
                r_extra_flag <= 1'b0;
                r_pend       <= 9'd0;
                r_frame_cnt  <= '0;
                r_lives      <= 3'(START_LIVES);
            end else begin
                r_pend <= w_pend_next;

                if (w_hit_acc) begin
                    r_hit_sem <= 1'b1;
                end else if (bus.startOfFrame) begin
                    r_hit_sem <= 1'b0;
                end

                if (w_hit_acc) begin
                    r_frame_cnt <= '0;
                end else if ((r_state == INVULN) && bus.startOfFrame
                             && (r_frame_cnt != FCW'(INVULN_FRAMES))) begin
                    r_frame_cnt <= r_frame_cnt + FCW'(1);
                end

                if (w_hit_acc) begin
                    r_lives <= r_lives - 3'd1;
                end else if (w_bonus) begin
                    r_extra_flag <= 1'b1;
                    if (r_lives < 3'(MAX_LIVES)) begin
                        r_lives <= r_lives + 3'd1;
                    end
                end
            end
        end
    end

    bcd_counter4 u_score (
        .clk     (clk),
        .resetN  (resetN),
        .i_clr   (w_start),
        .i_en    (w_drain),
        .o_count (w_score)
    );

    assign bus.scoreBCD     = w_score;
    assign bus.highScoreBCD = r_high;
    assign bus.lives        = r_lives;
    assign bus.gameLose     = (r_state == OVER);
    assign bus.invulnerable = (r_state == INVULN);
    assign bus.busy         = w_drain;

endmodule

// File: tb/tb_score_lives_keeper.sv
// tb/tb_score_lives_keeper.sv - self-checking bench for score_lives_keeper
module tb_score_lives_keeper;
    import score_lives_keeper_pkg::*;

    localparam int FRAME      = 70;
    localparam int INV_FRAMES = 60;

    logic clk = 1'b0;
    logic resetN;
    always #5 clk = ~clk;

    score_lives_keeper_if bus ();
    score_lives_keeper_if bus5 ();

    score_lives_keeper dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus)
    );

    score_lives_keeper #(.START_LIVES(5)) dut5 (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus5)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;
    int fcnt   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference model: points as plain integers, lives as a count, invulnerability as frames left.
    typedef struct {
        int points;
        int pend;
        int lives;
        int left;
        int high;
        bit active;
        bit over;
        bit inv;
        bit hit_frame;
        bit extra;
        bit sg_prev;
    } model_t;

    model_t m;

    function automatic model_t model_reset();
        model_t r;
        r.points = 0; r.pend = 0; r.lives = 3; r.left = 0; r.high = 0;
        r.active = 0; r.over = 0; r.inv = 0; r.hit_frame = 0; r.extra = 0; r.sg_prev = 0;
        return r;
    endfunction

    function automatic model_t model_step(input model_t cur, input bit sof, input bit sg,
                                          input int upd, input bit hit);
        model_t n;
        bit start;
        bit hit_ok;
        int add;
        n = cur;
        start = sg && !cur.sg_prev;
        n.sg_prev = sg;
        if (cur.points > cur.high) n.high = cur.points;
        if (start) begin
            n.points = 0; n.pend = 0; n.lives = 3; n.active = 1; n.over = 0;
            n.inv = 0; n.left = 0; n.hit_frame = 0; n.extra = 0;
            return n;
        end
        if (cur.pend > 0 && cur.points < 9999) n.points = cur.points + 1;
        add = (cur.active && upd != 0) ? upd : 0;
        n.pend = cur.pend + add - ((cur.pend > 0) ? 1 : 0);
        if (n.pend > 511) n.pend = 511;
        if (cur.inv) begin
            if (cur.left == 0) n.inv = 0;
            else if (sof) n.left = cur.left - 1;
        end
        hit_ok = cur.active && !cur.inv && hit && !cur.hit_frame;
        if (sof) n.hit_frame = 0;
        if (hit_ok) begin
            n.hit_frame = 1;
            n.lives = cur.lives - 1;
            if (cur.lives == 1) begin
                n.active = 0;
                n.over   = 1;
            end else begin
                n.inv  = 1;
                n.left = INV_FRAMES;
            end
        end else if (cur.active && !cur.extra && cur.points >= 1500) begin
            n.extra = 1;
            if (cur.lives < 5) n.lives = cur.lives + 1;
        end
        return n;
    endfunction

    function automatic bcd4_t to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    always @(posedge clk or negedge resetN) begin
        if (!resetN) m <= model_reset();
        else m <= model_step(m, bus.startOfFrame, bus.startGame, int'(bus.scoreUpdate), bus.playerHit);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_cycle",
                {26'd0, bus.scoreBCD, bus.highScoreBCD, bus.lives, bus.gameLose, bus.invulnerable, bus.busy},
                {26'd0, to_bcd(m.points), to_bcd(m.high), 3'(m.lives), m.over, m.inv, (m.pend != 0)});
        end
    end

    initial begin
        bus.startOfFrame = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            fcnt = (fcnt == FRAME - 1) ? 0 : fcnt + 1;
            bus.startOfFrame = (fcnt == 0);
        end
    end

    initial begin
        #950000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic step_in(input bit sg, input int upd, input bit hit);
        @(posedge clk);
        #2;
        bus.startGame   = sg;
        bus.scoreUpdate = 8'(upd);
        bus.playerHit   = hit;
    endtask

    task automatic wait_inv_low(input string name);
        int c;
        c = 0;
        while (bus.invulnerable && c < 6000) begin
            step_in(1, 0, 0);
            @(negedge clk);
            c++;
        end
        chk(name, (c < 6000), 1);
    endtask

    typedef struct {
        bit    sg;
        int    upd;
        int    wait_n;
        bcd4_t score;
        bcd4_t high;
        int    lives;
        bit    lose;
        bit    busy;
    } vec_t;

    vec_t vt[5];

    initial begin
        int sofs, bc, total, u, burst;
        bit seen, sgv, hv;

        vt[0] = '{1, 0,                3,   16'h0000, 16'h0000, 3, 0, 0};
        vt[1] = '{1, int'(BONUS_PTS),  1,   16'h0000, 16'h0000, 3, 0, 1};
        vt[2] = '{1, 30,               140, 16'h0130, 16'h0130, 3, 0, 0};
        vt[3] = '{0, 0,                3,   16'h0130, 16'h0130, 3, 0, 0};
        vt[4] = '{1, int'(ALIEN_PTS),  20,  16'h0000, 16'h0130, 3, 0, 0};

        resetN = 1'b0;
        bus.startGame = 1'b0; bus.scoreUpdate = 8'd0; bus.playerHit = 1'b0;
        bus5.startOfFrame = 1'b0; bus5.startGame = 1'b0; bus5.scoreUpdate = 8'd0; bus5.playerHit = 1'b0;
        repeat (3) @(posedge clk);
        #2 resetN = 1'b1;
        @(negedge clk);
        chk("rst_score", bus.scoreBCD, 16'h0000);
        chk("rst_high", bus.highScoreBCD, 16'h0000);
        chk("rst_lives", bus.lives, 3);
        chk("rst_lose", bus.gameLose, 0);
        chk("rst_inv", bus.invulnerable, 0);
        chk("rst_busy", bus.busy, 0);
        chk_en = 1'b1;

        for (int i = 0; i < 5; i++) begin
            step_in(vt[i].sg, vt[i].upd, 0);
            repeat (vt[i].wait_n) step_in(vt[i].sg, 0, 0);
            @(negedge clk);
            chk($sformatf("vec%0d_score", i), bus.scoreBCD, vt[i].score);
            chk($sformatf("vec%0d_high", i), bus.highScoreBCD, vt[i].high);
            chk($sformatf("vec%0d_lives", i), bus.lives, vt[i].lives);
            chk($sformatf("vec%0d_lose", i), bus.gameLose, vt[i].lose);
            chk($sformatf("vec%0d_busy", i), bus.busy, vt[i].busy);
        end

        // Long held hit: one life lost, then 60 frames of masking.
        step_in(1, 50, 0);
        sofs = 0;
        seen = 0;
        for (int c = 0; c < 6000; c++) begin
            step_in(1, 0, (c < 200));
            @(negedge clk);
            if (c == 199) begin
                chk("held_hit_lives", bus.lives, 2);
                chk("held_hit_inv", bus.invulnerable, 1);
            end
            if (bus.invulnerable) begin
                seen = 1;
                if (bus.startOfFrame) sofs++;
            end else if (seen && c >= 200) begin
                break;
            end
        end
        chk("inv_frames", sofs, INV_FRAMES);

        step_in(1, 0, 1);
        step_in(1, 0, 0);
        @(negedge clk);
        chk("second_hit_lives", bus.lives, 1);
        wait_inv_low("inv2_timeout");
        step_in(1, 0, 1);
        step_in(1, 0, 0);
        @(negedge clk);
        chk("last_hit_lives", bus.lives, 0);
        chk("last_hit_lose", bus.gameLose, 1);
        chk("over_score_before", bus.scoreBCD, 16'h0050);
        step_in(1, int'(ALIEN_PTS), 0);
        repeat (5) step_in(1, 0, 0);
        @(negedge clk);
        chk("over_upd_ignored", bus.scoreBCD, 16'h0050);
        chk("over_busy", bus.busy, 0);
        repeat (2) step_in(0, 0, 0);
        step_in(1, 0, 0);
        repeat (3) step_in(1, 0, 0);
        @(negedge clk);
        chk("restart_score", bus.scoreBCD, 16'h0000);
        chk("restart_lives", bus.lives, 3);
        chk("restart_lose", bus.gameLose, 0);
        chk("restart_high", bus.highScoreBCD, 16'h0130);

        // Climb to 9990, then overflow the score ceiling.
        total = 0;
        while (total < 9990) begin
            u = (9990 - total > 255) ? 255 : 9990 - total;
            step_in(1, u, 0);
            total += u;
            repeat (u + 2) step_in(1, 0, 0);
        end
        @(negedge clk);
        chk("preload_score", bus.scoreBCD, 16'h9990);
        chk("bonus_lives", bus.lives, 4);
        step_in(1, 30, 0);
        bc = 0;
        repeat (40) begin
            step_in(1, 0, 0);
            @(negedge clk);
            if (bus.busy) bc++;
        end
        chk("sat_busy_cycles", bc, 30);
        chk("sat_score", bus.scoreBCD, 16'h9999);
        chk("sat_high", bus.highScoreBCD, 16'h9999);

        // Bonus at the lives ceiling on an instance that starts with five lives.
        @(posedge clk);
        #2 bus5.startGame = 1'b1;
        repeat (3) @(posedge clk);
        repeat (6) begin
            @(posedge clk);
            #2 bus5.scoreUpdate = 8'd255;
            @(posedge clk);
            #2 bus5.scoreUpdate = 8'd0;
            repeat (260) @(posedge clk);
        end
        @(negedge clk);
        chk("cap_score", bus5.scoreBCD, 16'h1530);
        chk("cap_lives", bus5.lives, 5);

        // Randomised play against the model.
        repeat (2) step_in(0, 0, 0);
        sgv = 1;
        burst = 0;
        for (int c = 0; c < 15000; c++) begin
            if ($urandom_range(0, 999) == 0) sgv = !sgv;
            if (burst == 0 && $urandom_range(0, 99) == 0) burst = $urandom_range(1, 150);
            hv = (burst > 0);
            if (burst > 0) burst--;
            step_in(sgv, ($urandom_range(0, 19) == 0) ? $urandom_range(1, 255) : 0, hv);
        end
        @(negedge clk);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
